// File: rtl/ucie_ctl_sb_pkg.sv
// Shared sideband definitions used by the TX sender and RX receiver.
//   SB_PHASE_W            : width of one sideband message phase
//   ST_IDLE / ST_COLLECT  : deserializer FSM encoding
//   sb_nc_legal()         : true for the supported RDI config bus widths
package ucie_ctl_sb_pkg;

  localparam int SB_PHASE_W = 32;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  function automatic bit sb_nc_legal(input int nc);
    return (nc == 8) || (nc == 16) || (nc == 32);
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_rx_packet_receiver_if.sv
// Sideband RX bus between the RDI config stream, the packet receiver and
// the downstream message decoder.
//   i_rdi_pl_cfg / i_rdi_pl_cfg_vld : incoming NC-bit chunk and its valid
//   i_phase_ack                     : consumer accepts the presented phase
//   o_phase_received / o_phase_vld  : assembled 32-bit phase, level valid
//   o_frame_err / o_overrun         : one-cycle error pulses
//   o_busy                          : partial phase in progress
// slave  : the receiver side; master : the stimulus/consumer side.
interface ucie_ctl_sb_rx_packet_receiver_if
  import ucie_ctl_sb_pkg::*;
#(
  parameter int NC = 8
);

  logic [NC-1:0]         i_rdi_pl_cfg;
  logic                  i_rdi_pl_cfg_vld;
  logic                  i_phase_ack;
  logic [SB_PHASE_W-1:0] o_phase_received;
  logic                  o_phase_vld;
  logic                  o_frame_err;
  logic                  o_overrun;
  logic                  o_busy;

  modport slave (
    input  i_rdi_pl_cfg, i_rdi_pl_cfg_vld, i_phase_ack,
    output o_phase_received, o_phase_vld, o_frame_err, o_overrun, o_busy
  );

  modport master (
    output i_rdi_pl_cfg, i_rdi_pl_cfg_vld, i_phase_ack,
    input  o_phase_received, o_phase_vld, o_frame_err, o_overrun, o_busy
  );

endinterface

// File: rtl/ucie_ctl_sb_rx_packet_receiver.sv
// Sideband RX deserializer. Collects NC-bit chunks (LSB chunk first) from
// the RDI config bus into 32-bit phases and presents each completed phase
// with a level valid that is held until acknowledged.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : ucie_ctl_sb_rx_packet_receiver_if.slave (see interface)
module ucie_ctl_sb_rx_packet_receiver
  import ucie_ctl_sb_pkg::*;
#(
  parameter int NC = 8
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  ucie_ctl_sb_rx_packet_receiver_if.slave        bus
);

  localparam int COUNT = SB_PHASE_W / NC - 1;
  localparam int CW    = (COUNT > 0) ? $clog2(COUNT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  generate
    if (!sb_nc_legal(NC)) begin : g_bad_nc
      $error("ucie_ctl_sb_rx_packet_receiver: NC must be 8, 16 or 32");
    end
  endgenerate

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SB_PHASE_W-1:0] asm_q, asm_d;
  logic [SB_PHASE_W-1:0] phase_q, phase_d;
  logic                  pvld_q, pvld_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  logic [CW-1:0]         wr_idx;
  logic [SB_PHASE_W-1:0] merged;
  logic                  complete;

  // Current assembly with the incoming chunk dropped into place. Outside
  // COLLECT the base is zero, which clears stale bits at each phase start.
  always_comb begin
    wr_idx = (state_q == ST_COLLECT) ? cnt_q : '0;
    merged = (state_q == ST_COLLECT) ? asm_q : '0;
    merged[int'(wr_idx) * NC +: NC] = bus.i_rdi_pl_cfg;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    ferr_d   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_rdi_pl_cfg_vld) begin
          if (COUNT == 0) begin
            complete = 1'b1;
          end else begin
            asm_d   = merged;
            cnt_d   = ONE;
            state_d = ST_COLLECT;
          end
        end
      end
      default: begin
        if (bus.i_rdi_pl_cfg_vld) begin
          asm_d = merged;
          if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          // Valid dropped inside a phase: abandon the partial data.
          ferr_d  = 1'b1;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Completion wins over ack, so a same-cycle ack+complete keeps valid high.
  always_comb begin
    phase_d = complete ? merged : phase_q;
    pvld_d  = complete ? 1'b1 : (pvld_q & ~bus.i_phase_ack);
    ovr_d   = complete & pvld_q & ~bus.i_phase_ack;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      phase_q <= '0;
      pvld_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      phase_q <= phase_d;
      pvld_q  <= pvld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.o_phase_received = phase_q;
  assign bus.o_phase_vld      = pvld_q;
  assign bus.o_frame_err      = ferr_q;
  assign bus.o_overrun        = ovr_q;
  assign bus.o_busy           = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_ucie_ctl_sb_rx_packet_receiver.sv
module tb_ucie_ctl_sb_rx_packet_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp8[$];
  logic [31:0] exp16[$];
  logic [31:0] exp32[$];

  always #5 clk = ~clk;

  ucie_ctl_sb_rx_packet_receiver_if #(.NC(8))  if8 ();
  ucie_ctl_sb_rx_packet_receiver_if #(.NC(16)) if16 ();
  ucie_ctl_sb_rx_packet_receiver_if #(.NC(32)) if32 ();

  ucie_ctl_sb_rx_packet_receiver #(.NC(8))  u8  (.i_clk(clk), .i_rst(rst), .bus(if8));
  ucie_ctl_sb_rx_packet_receiver #(.NC(16)) u16 (.i_clk(clk), .i_rst(rst), .bus(if16));
  ucie_ctl_sb_rx_packet_receiver #(.NC(32)) u32 (.i_clk(clk), .i_rst(rst), .bus(if32));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if8.i_rdi_pl_cfg = '0;  if8.i_rdi_pl_cfg_vld = 1'b0;  if8.i_phase_ack = 1'b0;
    if16.i_rdi_pl_cfg = '0; if16.i_rdi_pl_cfg_vld = 1'b0; if16.i_phase_ack = 1'b0;
    if32.i_rdi_pl_cfg = '0; if32.i_rdi_pl_cfg_vld = 1'b0; if32.i_phase_ack = 1'b0;
  endtask

  // Outputs of all three instances packed as {data, vld, ferr, ovr, busy}.
  function automatic logic [35:0] out8();
    return {if8.o_phase_received, if8.o_phase_vld, if8.o_frame_err, if8.o_overrun, if8.o_busy};
  endfunction
  function automatic logic [35:0] out16();
    return {if16.o_phase_received, if16.o_phase_vld, if16.o_frame_err, if16.o_overrun, if16.o_busy};
  endfunction
  function automatic logic [35:0] out32();
    return {if32.o_phase_received, if32.o_phase_vld, if32.o_frame_err, if32.o_overrun, if32.o_busy};
  endfunction

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    #3;
    checks++;
    if (out8() !== 36'h0) begin
      errors++; $display("FAIL reset_nc8: got %h expected 0", out8());
    end
    checks++;
    if (out16() !== 36'h0) begin
      errors++; $display("FAIL reset_nc16: got %h expected 0", out16());
    end
    checks++;
    if (out32() !== 36'h0) begin
      errors++; $display("FAIL reset_nc32: got %h expected 0", out32());
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_nc8_basic();
    logic [7:0] ch[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      if8.i_rdi_pl_cfg = ch[i]; if8.i_rdi_pl_cfg_vld = 1'b1;
      if (i == 3) exp8.push_back(32'h12345678);
      step();
      checks++;
      if (if8.o_busy !== (i < 3)) begin
        errors++; $display("FAIL basic_busy[%0d]: got %b expected %b", i, if8.o_busy, (i < 3));
      end
    end
    if8.i_rdi_pl_cfg_vld = 1'b0;
    checks++;
    if (if8.o_phase_vld !== 1'b1 || exp8.size() == 0) begin
      errors++; $display("FAIL basic_vld: got %b expected 1", if8.o_phase_vld);
    end else begin
      e = exp8.pop_front();
      checks++;
      if (if8.o_phase_received !== e) begin
        errors++; $display("FAIL basic_data: got %h expected %h", if8.o_phase_received, e);
      end
    end
    step();
    checks++;
    if (if8.o_phase_vld !== 1'b1 || if8.o_frame_err !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got vld=%b ferr=%b expected vld=1 ferr=0",
                         if8.o_phase_vld, if8.o_frame_err);
    end
    if8.i_phase_ack = 1'b1;
    step();
    if8.i_phase_ack = 1'b0;
    checks++;
    if (if8.o_phase_vld !== 1'b0) begin
      errors++; $display("FAIL basic_ack: got %b expected 0", if8.o_phase_vld);
    end
  endtask

  task automatic test_nc16_ack();
    logic [15:0] ch[4] = '{16'hBEEF, 16'hDEAD, 16'h5678, 16'h1234};
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      if16.i_rdi_pl_cfg = ch[i]; if16.i_rdi_pl_cfg_vld = 1'b1; if16.i_phase_ack = 1'b1;
      if (i == 1) exp16.push_back(32'hDEADBEEF);
      if (i == 3) exp16.push_back(32'h12345678);
      step();
      checks++;
      if (if16.o_phase_vld !== (i == 1 || i == 3) || if16.o_overrun !== 1'b0 ||
          if16.o_frame_err !== 1'b0) begin
        errors++; $display("FAIL ack16_flags[%0d]: got vld=%b ovr=%b ferr=%b expected vld=%b ovr=0 ferr=0",
                           i, if16.o_phase_vld, if16.o_overrun, if16.o_frame_err, (i == 1 || i == 3));
      end
      if ((i == 1 || i == 3) && exp16.size() > 0) begin
        e = exp16.pop_front();
        checks++;
        if (if16.o_phase_received !== e) begin
          errors++; $display("FAIL ack16_data[%0d]: got %h expected %h", i, if16.o_phase_received, e);
        end
      end
    end
    if16.i_rdi_pl_cfg_vld = 1'b0;
    step();
    if16.i_phase_ack = 1'b0;
    checks++;
    if (if16.o_frame_err !== 1'b0 || if16.o_phase_vld !== 1'b0) begin
      errors++; $display("FAIL ack16_end: got ferr=%b vld=%b expected 0 0", if16.o_frame_err, if16.o_phase_vld);
    end
  endtask

  task automatic nc8_phase(input logic [31:0] d, input string tag);
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      if8.i_rdi_pl_cfg = d[i*8 +: 8]; if8.i_rdi_pl_cfg_vld = 1'b1;
      if (i == 3) exp8.push_back(d);
      step();
    end
    if8.i_rdi_pl_cfg_vld = 1'b0;
    checks++;
    if (if8.o_phase_vld !== 1'b1 || exp8.size() == 0) begin
      errors++; $display("FAIL %s_vld: got %b expected 1", tag, if8.o_phase_vld);
    end else begin
      e = exp8.pop_front();
      checks++;
      if (if8.o_phase_received !== e) begin
        errors++; $display("FAIL %s_data: got %h expected %h", tag, if8.o_phase_received, e);
      end
    end
    if8.i_phase_ack = 1'b1;
    step();
    if8.i_phase_ack = 1'b0;
  endtask

  task automatic test_frame_err();
    if8.i_rdi_pl_cfg = 8'hAA; if8.i_rdi_pl_cfg_vld = 1'b1;
    step();
    if8.i_rdi_pl_cfg = 8'hBB;
    step();
    checks++;
    if (if8.o_busy !== 1'b1) begin
      errors++; $display("FAIL ferr_busy: got %b expected 1", if8.o_busy);
    end
    if8.i_rdi_pl_cfg_vld = 1'b0;
    step();
    checks++;
    if (if8.o_frame_err !== 1'b1 || if8.o_busy !== 1'b0 || if8.o_phase_vld !== 1'b0) begin
      errors++; $display("FAIL ferr_pulse: got ferr=%b busy=%b vld=%b expected 1 0 0",
                         if8.o_frame_err, if8.o_busy, if8.o_phase_vld);
    end
    step();
    checks++;
    if (if8.o_frame_err !== 1'b0) begin
      errors++; $display("FAIL ferr_width: got %b expected 0", if8.o_frame_err);
    end
    nc8_phase(32'hA5A5A5A5, "ferr_recover");
  endtask

  task automatic test_overrun();
    logic [31:0] e;
    logic [31:0] d[2] = '{32'h11111111, 32'h22222222};
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        if8.i_rdi_pl_cfg = d[p][i*8 +: 8]; if8.i_rdi_pl_cfg_vld = 1'b1;
        if (i == 3) exp8.push_back(d[p]);
        step();
      end
      checks++;
      if (if8.o_phase_vld !== 1'b1 || if8.o_overrun !== (p == 1)) begin
        errors++; $display("FAIL ovr_flags[%0d]: got vld=%b ovr=%b expected vld=1 ovr=%b",
                           p, if8.o_phase_vld, if8.o_overrun, (p == 1));
      end
      if (exp8.size() > 0) begin
        e = exp8.pop_front();
        checks++;
        if (if8.o_phase_received !== e) begin
          errors++; $display("FAIL ovr_data[%0d]: got %h expected %h", p, if8.o_phase_received, e);
        end
      end
    end
    if8.i_rdi_pl_cfg_vld = 1'b0;
    step();
    checks++;
    if (if8.o_overrun !== 1'b0 || if8.o_phase_vld !== 1'b1 || if8.o_phase_received !== 32'h22222222) begin
      errors++; $display("FAIL ovr_after: got ovr=%b vld=%b data=%h expected 0 1 22222222",
                         if8.o_overrun, if8.o_phase_vld, if8.o_phase_received);
    end
    if8.i_phase_ack = 1'b1;
    step();
    if8.i_phase_ack = 1'b0;
  endtask

  task automatic test_nc32();
    logic [31:0] e;
    if32.i_rdi_pl_cfg = 32'hCAFEF00D; if32.i_rdi_pl_cfg_vld = 1'b1;
    exp32.push_back(32'hCAFEF00D);
    checks++;
    if (if32.o_busy !== 1'b0) begin
      errors++; $display("FAIL nc32_busy0: got %b expected 0", if32.o_busy);
    end
    step();
    if32.i_rdi_pl_cfg = 32'h0BADBEEF; if32.i_phase_ack = 1'b1;
    e = exp32.pop_front();
    exp32.push_back(32'h0BADBEEF);
    checks++;
    if (if32.o_phase_vld !== 1'b1 || if32.o_phase_received !== e || if32.o_busy !== 1'b0) begin
      errors++; $display("FAIL nc32_first: got vld=%b data=%h busy=%b expected 1 %h 0",
                         if32.o_phase_vld, if32.o_phase_received, if32.o_busy, e);
    end
    step();
    if32.i_rdi_pl_cfg_vld = 1'b0;
    e = exp32.pop_front();
    checks++;
    if (if32.o_phase_vld !== 1'b1 || if32.o_phase_received !== e || if32.o_overrun !== 1'b0 ||
        if32.o_busy !== 1'b0) begin
      errors++; $display("FAIL nc32_ackload: got vld=%b data=%h ovr=%b busy=%b expected 1 %h 0 0",
                         if32.o_phase_vld, if32.o_phase_received, if32.o_overrun, if32.o_busy, e);
    end
    step();
    if32.i_phase_ack = 1'b0;
    checks++;
    if (if32.o_phase_vld !== 1'b0) begin
      errors++; $display("FAIL nc32_clear: got %b expected 0", if32.o_phase_vld);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] ch[3] = '{8'h21, 8'h43, 8'h65};
    for (int i = 0; i < 3; i++) begin
      if8.i_rdi_pl_cfg = ch[i]; if8.i_rdi_pl_cfg_vld = 1'b1;
      step();
    end
    if8.i_rdi_pl_cfg_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out8() !== 36'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", out8());
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (if8.o_frame_err !== 1'b0 || if8.o_busy !== 1'b0) begin
      errors++; $display("FAIL async_noerr: got ferr=%b busy=%b expected 0 0", if8.o_frame_err, if8.o_busy);
    end
    nc8_phase(32'h87654321, "async_recover");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    for (int p = 0; p < 5; p++) begin
      d = $urandom();
      for (int i = 0; i < 2; i++) begin
        if16.i_rdi_pl_cfg = d[i*16 +: 16]; if16.i_rdi_pl_cfg_vld = 1'b1; if16.i_phase_ack = 1'b1;
        if (i == 1) exp16.push_back(d);
        step();
        checks++;
        if (if16.o_phase_vld !== (i == 1) || if16.o_overrun !== 1'b0 || if16.o_frame_err !== 1'b0) begin
          errors++; $display("FAIL b2b_flags[%0d.%0d]: got vld=%b ovr=%b ferr=%b expected vld=%b ovr=0 ferr=0",
                             p, i, if16.o_phase_vld, if16.o_overrun, if16.o_frame_err, (i == 1));
        end
      end
      if (exp16.size() > 0) begin
        e = exp16.pop_front();
        checks++;
        if (if16.o_phase_received !== e) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", p, if16.o_phase_received, e);
        end
      end
    end
    if16.i_rdi_pl_cfg_vld = 1'b0;
    step();
    if16.i_phase_ack = 1'b0;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_nc8_basic();
    test_nc16_ack();
    test_frame_err();
    test_overrun();
    test_nc32();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (exp8.size() + exp16.size() + exp32.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0",
                         exp8.size() + exp16.size() + exp32.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
